// File: rtl/tx_serial_pkg.sv
// tx_serial_pkg: shared parity modes, FSM encoding and frame-length helper for the serial transmitter
package tx_serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [1:0] {
        REPOUSO   = 2'd0,
        CARREGA   = 2'd1,
        TRANSMITE = 2'd2,
        FINAL     = 2'd3
    } estado_t;

    function automatic int nbits(input int data_bits, input int paridade, input int stop_bits);
        return 1 + data_bits + ((paridade != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M counter with synchronous clear, flags the last count of each period
module contador_m #(
    parameter int M = 16,
    parameter int N = 4
) (
    input  logic clock,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    // count 0..M-1 while enabled, wrapping back to zero
    always_ff @(posedge clock) begin
        if (zera_s)
            q <= '0;
        else if (conta)
            q <= (q == N'(M - 1)) ? '0 : q + N'(1);
    end

    assign fim = (q == N'(M - 1));

endmodule

// File: rtl/tx_serial_param.sv
// tx_serial_param: parametrised async serial transmitter with a one-entry holding buffer
module tx_serial_param import tx_serial_pkg::*; #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARIDADE   = PAR_ODD,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 envia,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 livre,
    output logic                 ocupado,
    output logic                 pronto,
    output logic                 saida_serial,
    output logic                 db_tick,
    output logic [3:0]           db_estado,
    output logic [3:0]           db_contagem
);

    localparam int DIVISOR = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int NB      = nbits(DATA_BITS, PARIDADE, STOP_BITS);
    localparam int CW      = $clog2(DIVISOR);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARIDADE < PAR_NONE || PARIDADE > PAR_ODD ||
        !(STOP_BITS == 1 || STOP_BITS == 2) || DIVISOR < 2) begin : g_param_err
        $error("tx_serial_param: illegal parameter combination");
    end

    estado_t              estado;
    logic                 cheio;
    logic [DATA_BITS-1:0] buf_dados;
    logic                 buf_par;
    logic [NB-1:0]        shift_reg;
    logic [NB-1:0]        quadro;
    logic [3:0]           indice;
    logic                 tick;

    contador_m #(.M(DIVISOR), .N(CW)) u_tick (
        .clock  (clock),
        .zera_s (reset || estado == CARREGA),
        .conta  (estado == TRANSMITE),
        .fim    (tick)
    );

    // holding buffer: capture a character and its parity when empty, release it on load
    always_ff @(posedge clock) begin
        if (reset) begin
            cheio <= 1'b0;
        end else if (envia && !cheio) begin
            cheio     <= 1'b1;
            buf_dados <= dados;
            buf_par   <= (^dados) ^ (PARIDADE == PAR_ODD);
        end else if (estado == CARREGA) begin
            cheio <= 1'b0;
        end
    end

    // frame image, start bit in bit 0; stop bits fill everything above data/parity
    always_comb begin
        quadro = {{(NB - DATA_BITS - 1){1'b1}}, buf_dados, 1'b0};
        quadro[DATA_BITS + 1] = (PARIDADE != PAR_NONE) ? buf_par : 1'b1;
    end

    // control FSM; the line is bit 0 of a shift register that idles all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= REPOUSO;
            shift_reg <= '1;
            indice    <= '0;
            pronto    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                REPOUSO: begin
                    if (cheio)
                        estado <= CARREGA;
                end
                CARREGA: begin
                    shift_reg <= quadro;
                    indice    <= '0;
                    estado    <= TRANSMITE;
                end
                TRANSMITE: begin
                    if (tick) begin
                        shift_reg <= {1'b1, shift_reg[NB-1:1]};
                        indice    <= indice + 4'd1;
                        if (indice == 4'(NB - 1)) begin
                            estado <= FINAL;
                            pronto <= 1'b1;
                        end
                    end
                end
                FINAL: begin
                    estado <= cheio ? CARREGA : REPOUSO;
                end
            endcase
        end
    end

    assign livre        = !cheio;
    assign ocupado      = (estado != REPOUSO);
    assign saida_serial = shift_reg[0];
    assign db_tick      = tick;
    assign db_estado    = {2'b00, estado};
    assign db_contagem  = indice;

endmodule

// File: tb/tb_tx_serial_param.sv
// tb_tx_serial_param: three transmitter configurations checked against a timing/frame model
module tb_tx_serial_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] envia = '0;
    logic [8:0] dados [3];
    logic [2:0] livre, ocupado, pronto, saida, tick;
    logic [3:0] est  [3];
    logic [3:0] cont [3];

    int checks = 0;
    int errors = 0;

    int cfg_d   [3] = '{10, 4, 3};
    int cfg_db  [3] = '{8, 7, 5};
    int cfg_par [3] = '{2, 1, 0};
    int cfg_sb  [3] = '{1, 2, 1};

    logic       tr_line [$];
    logic       tr_pr   [$];
    logic       tr_lv   [$];
    logic       tr_oc   [$];
    int         acc_t   [$];
    logic [8:0] acc_d   [$];
    logic [8:0] pend    [$];
    int         t;
    int         tick_cnt;
    logic       livre_prev;

    always #5 clock = ~clock;

    tx_serial_param #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut_a (
        .clock(clock), .reset(reset), .envia(envia[0]), .dados(dados[0][7:0]),
        .livre(livre[0]), .ocupado(ocupado[0]), .pronto(pronto[0]), .saida_serial(saida[0]),
        .db_tick(tick[0]), .db_estado(est[0]), .db_contagem(cont[0]));

    tx_serial_param #(.CLOCK_FREQ(1000), .BAUD_RATE(250), .DATA_BITS(7), .PARIDADE(1), .STOP_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .envia(envia[1]), .dados(dados[1][6:0]),
        .livre(livre[1]), .ocupado(ocupado[1]), .pronto(pronto[1]), .saida_serial(saida[1]),
        .db_tick(tick[1]), .db_estado(est[1]), .db_contagem(cont[1]));

    tx_serial_param #(.CLOCK_FREQ(1000), .BAUD_RATE(333), .DATA_BITS(5), .PARIDADE(0), .STOP_BITS(1)) dut_c (
        .clock(clock), .reset(reset), .envia(envia[2]), .dados(dados[2][4:0]),
        .livre(livre[2]), .ocupado(ocupado[2]), .pronto(pronto[2]), .saida_serial(saida[2]),
        .db_tick(tick[2]), .db_estado(est[2]), .db_contagem(cont[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int k);
        return 1 + cfg_db[k] + ((cfg_par[k] != 0) ? 1 : 0) + cfg_sb[k];
    endfunction

    function automatic logic frame_bit(input int k, input logic [8:0] d, input int i);
        int db   = cfg_db[k];
        int ones = $countones(d & 9'((1 << db) - 1));
        if (i == 0) return 1'b0;
        if (i <= db) return d[i-1];
        if (cfg_par[k] != 0 && i == db + 1) return (cfg_par[k] == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic begin_session(input int k);
        tr_line.delete(); tr_pr.delete(); tr_lv.delete(); tr_oc.delete();
        acc_t.delete(); acc_d.delete(); pend.delete();
        t = 0;
        tick_cnt = 0;
        livre_prev = livre[k];
    endtask

    task automatic queue_now(input int k, input logic [8:0] d);
        pend.push_back(d);
        envia[k] = 1'b1;
        dados[k] = pend[0];
    endtask

    task automatic step(input int k);
        @(negedge clock);
        if (envia[k] && livre_prev) begin
            acc_t.push_back(t);
            acc_d.push_back(dados[k]);
            if (pend.size() > 0) pend.delete(0);
        end
        tr_line.push_back(saida[k]);
        tr_pr.push_back(pronto[k]);
        tr_lv.push_back(livre[k]);
        tr_oc.push_back(ocupado[k]);
        tick_cnt += int'(tick[k]);
        livre_prev = livre[k];
        t++;
        envia[k] = (pend.size() > 0);
        if (pend.size() > 0) dados[k] = pend[0];
    endtask

    task automatic drain(input int k);
        int g = 0;
        while ((pend.size() > 0 || envia[k] || !livre[k] || ocupado[k]) && g < 3000) begin
            step(k);
            g++;
        end
        chk("drain_timeout", g < 3000, 1);
        repeat (3) step(k);
    endtask

    task automatic check_trace(input int k, input int nframes, input string tag);
        int   d = cfg_d[k];
        int   len = frame_len(k) * d;
        int   prev_end = -100;
        int   s;
        logic el [], ep [], elv [], eo [];
        el = new[t]; ep = new[t]; elv = new[t]; eo = new[t];
        for (int i = 0; i < t; i++) begin
            el[i] = 1'b1; ep[i] = 1'b0; elv[i] = 1'b1; eo[i] = 1'b0;
        end
        chk({tag, "_frames"}, acc_t.size(), nframes);
        foreach (acc_t[j]) begin
            s = (acc_t[j] > prev_end) ? acc_t[j] + 2 : prev_end + 2;
            for (int i = 0; i < len; i++) if (s + i < t) el[s+i] = frame_bit(k, acc_d[j], i / d);
            for (int i = acc_t[j]; i < s && i < t; i++) elv[i] = 1'b0;
            for (int i = s - 1; i <= s + len && i < t; i++) eo[i] = 1'b1;
            if (s + len < t) ep[s+len] = 1'b1;
            prev_end = s + len;
        end
        chk({tag, "_complete"}, prev_end < t, 1);
        chk({tag, "_ticks"}, tick_cnt, nframes * frame_len(k));
        for (int i = 0; i < t; i++) begin
            chk($sformatf("%s_line@%0d", tag, i), tr_line[i], el[i]);
            chk($sformatf("%s_pronto@%0d", tag, i), tr_pr[i], ep[i]);
            chk($sformatf("%s_livre@%0d", tag, i), tr_lv[i], elv[i]);
            chk($sformatf("%s_ocupado@%0d", tag, i), tr_oc[i], eo[i]);
        end
    endtask

    function automatic int first_low();
        foreach (tr_line[i]) if (tr_line[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int first_pronto();
        foreach (tr_pr[i]) if (tr_pr[i] === 1'b1) return i;
        return -1;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, np, nl;
        for (int k = 0; k < 3; k++) dados[k] = '0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_line%0d", k), saida[k], 1);
            chk($sformatf("rst_livre%0d", k), livre[k], 1);
            chk($sformatf("rst_ocupado%0d", k), ocupado[k], 0);
            chk($sformatf("rst_pronto%0d", k), pronto[k], 0);
            chk($sformatf("rst_estado%0d", k), est[k], 0);
            chk($sformatf("rst_contagem%0d", k), cont[k], 0);
        end
        reset = 1'b0;

        begin_session(0);
        queue_now(0, 9'h041);
        drain(0);
        check_trace(0, 1, "a41");
        chk("a41_start_latency", first_low(), 2);
        chk("a41_pronto_delay", first_pronto() - first_low(), 110);

        begin_session(1);
        queue_now(1, 9'h055);
        drain(1);
        check_trace(1, 1, "b55");
        chk("b55_frame_len", first_pronto() - first_low(), 44);

        begin_session(0);
        pend.push_back(9'h0A5);
        queue_now(0, 9'h03C);
        drain(0);
        check_trace(0, 2, "b2b");

        begin_session(0);
        queue_now(0, 9'h012);
        step(0);
        chk("ign_livre_a", livre[0], 0);
        envia[0] = 1'b1; dados[0] = 9'h0FF;
        step(0);
        chk("ign_livre_b", livre[0], 0);
        chk("ign_carrega", est[0], 1);
        envia[0] = 1'b1; dados[0] = 9'h0FF;
        step(0);
        drain(0);
        check_trace(0, 1, "ign");

        begin_session(2);
        queue_now(2, 9'h01F);
        drain(2);
        check_trace(2, 1, "c1f");

        begin_session(2);
        queue_now(2, 9'h00A);
        g = 0;
        while (!(tr_pr.size() > 0 && tr_pr[$] === 1'b1) && g < 200) begin
            step(2);
            g++;
        end
        chk("fin_wait", g < 200, 1);
        queue_now(2, 9'h015);
        drain(2);
        check_trace(2, 2, "fin");

        begin_session(0);
        queue_now(0, 9'h041);
        g = 0;
        while (saida[0] !== 1'b0 && g < 20) begin
            step(0);
            g++;
        end
        chk("mid_start_wait", g < 20, 1);
        repeat (43) step(0);
        chk("mid_contagem", cont[0], 4);
        chk("mid_bit3", saida[0], 0);
        queue_now(0, 9'h077);
        step(0);
        chk("mid_buffered", livre[0], 0);
        reset = 1'b1;
        step(0);
        chk("mid_rst_line", saida[0], 1);
        chk("mid_rst_livre", livre[0], 1);
        chk("mid_rst_ocupado", ocupado[0], 0);
        chk("mid_rst_pronto", pronto[0], 0);
        chk("mid_rst_estado", est[0], 0);
        reset = 1'b0;
        np = 0; nl = 0;
        repeat (150) begin
            step(0);
            np += int'(pronto[0]);
            nl += int'(!saida[0]);
        end
        chk("mid_no_pronto", np, 0);
        chk("mid_no_frame", nl, 0);
        begin_session(0);
        queue_now(0, 9'h000);
        drain(0);
        check_trace(0, 1, "after_rst");

        for (int k = 0; k < 3; k++) begin
            begin_session(k);
            for (int n = 0; n < 5; n++) begin
                pend.push_back(9'($urandom));
                repeat ($urandom_range(0, frame_len(k) * cfg_d[k] + 4)) step(k);
            end
            drain(k);
            check_trace(k, 5, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
